// File: rtl/uart_alu_seq.sv
// uart_alu_seq
// Frame sequencer between a UART receiver/transmitter pair and a
// combinational ALU. A frame is SYNC_BYTE, operand A, operand B and an opcode
// byte. The sequencer latches the operands and opcode, strobes the ALU for one
// cycle, captures the result and hands it to the transmitter. It then waits
// for the transmitter to finish before it accepts the next frame.
//
// Optional feature: define UART_ALU_SEQ_TIMEOUT_EN to add an inter-byte
// timeout. If no byte arrives within TIMEOUT_CYCLES, the GET_* states abort
// back to IDLE and flag a frame error.
//
// Ports
//   clk           clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_rx_done     one-cycle pulse per received byte
//   i_alu_result  combinational ALU result
//   i_tx_done     one-cycle pulse when the transmitter finishes
//   o_alu_a       ALU operand A
//   o_alu_b       ALU operand B
//   o_alu_op      ALU opcode
//   o_alu_valid   one-cycle execute strobe, high during EXEC
//   o_tx_data     captured ALU result for the transmitter
//   o_tx_start    one-cycle transmit request, high during SEND
//   o_busy        high in every state except IDLE
//   o_frame_err   one-cycle pulse for a bad header, an overrun or a timeout
//
// state   | meaning
// IDLE    | waiting for SYNC_BYTE
// GET_A   | waiting for operand A
// GET_B   | waiting for operand B
// GET_OP  | waiting for opcode byte
// EXEC    | ALU strobe; result captured at the end of the cycle
// SEND    | transmit request
// WAIT_TX | waiting for the transmitter to finish

module uart_alu_seq #(
    parameter int                   NB_DATA        = 8,
    parameter int                   NB_OP          = 6,
    parameter logic [NB_DATA-1:0]   SYNC_BYTE      = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_frame_err
);

    if (NB_OP > NB_DATA) begin : g_bad_op_width
        $error("uart_alu_seq: NB_OP must not exceed NB_DATA");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_alu_seq: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        GET_OP  = 3'd3,
        EXEC    = 3'd4,
        SEND    = 3'd5,
        WAIT_TX = 3'd6
    } state_t;

    state_t state;
    state_t state_next;
    logic   frame_err_next;
    logic   in_get;
    logic   timeout;

    assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_OP);

`ifdef UART_ALU_SEQ_TIMEOUT_EN
    localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_TMO-1:0] tmo_cnt;

    // The counter rests at zero outside the GET_* states, so every entry to
    // GET_A starts from zero. Each received byte restarts the count.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_get || i_rx_done || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = in_get && (tmo_cnt == NB_TMO'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_next;
            o_frame_err <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == SYNC_BYTE) state_next = GET_A;
                    else                        frame_err_next = 1'b1;
                end
            end
            GET_A:   if (i_rx_done) state_next = GET_B;
            GET_B:   if (i_rx_done) state_next = GET_OP;
            GET_OP:  if (i_rx_done) state_next = EXEC;
            EXEC: begin
                state_next     = SEND;
                frame_err_next = i_rx_done;
            end
            SEND: begin
                state_next     = WAIT_TX;
                frame_err_next = i_rx_done;
            end
            WAIT_TX: begin
                if (i_tx_done) state_next = IDLE;
                frame_err_next = i_rx_done;
            end
            default: state_next = IDLE;
        endcase

        // A timeout wins over a byte arriving in the same cycle.
        if (timeout) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            if (i_rx_done && !timeout) begin
                if (state == GET_A)  o_alu_a  <= i_rx_data;
                if (state == GET_B)  o_alu_b  <= i_rx_data;
                if (state == GET_OP) o_alu_op <= i_rx_data[NB_OP-1:0];
            end
            if (state == EXEC) o_tx_data <= i_alu_result;
        end
    end

    assign o_alu_valid = (state == EXEC);
    assign o_tx_start  = (state == SEND);
    assign o_busy      = (state != IDLE);

endmodule

// File: doc/uart_alu_seq.md
UART_ALU_SEQ -- requirements
Module: uart_alu_seq

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, meaning the width of UART bytes, ALU operands and the ALU result.
REQ-002 SHALL have parameter NB_OP, default 6, meaning the ALU opcode width (NB_OP <= NB_DATA).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame header value.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the inter-byte timeout in clk cycles (used only under UART_ALU_SEQ_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_rx_data, input, NB_DATA bits: received UART byte, valid while i_rx_done=1.
REQ-008 SHALL have port i_rx_done, input, 1 bit: single-cycle pulse marking a received byte.
REQ-009 SHALL have port i_alu_result, input, NB_DATA bits: combinational ALU output.
REQ-010 SHALL have port i_tx_done, input, 1 bit: single-cycle pulse marking transmitter completion.
REQ-011 SHALL have port o_alu_a, output, NB_DATA bits: ALU operand A.
REQ-012 SHALL have port o_alu_b, output, NB_DATA bits: ALU operand B.
REQ-013 SHALL have port o_alu_op, output, NB_OP bits: ALU opcode.
REQ-014 SHALL have port o_alu_valid, output, 1 bit: one-cycle execute strobe.
REQ-015 SHALL have port o_tx_data, output, NB_DATA bits: byte for the UART transmitter.
REQ-016 SHALL have port o_tx_start, output, 1 bit: one-cycle transmit request.
REQ-017 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port o_frame_err, output, 1 bit: one-cycle error pulse.

Function
REQ-019 SHALL implement a registered FSM with the states IDLE, GET_A, GET_B, GET_OP, EXEC, SEND and WAIT_TX.
REQ-020 IDLE: an i_rx_done with i_rx_data==SYNC_BYTE SHALL go to GET_A; an i_rx_done with any other byte SHALL stay in IDLE and pulse o_frame_err for one cycle.
REQ-021 GET_A: an i_rx_done SHALL register i_rx_data into o_alu_a and go to GET_B.
REQ-022 GET_B: an i_rx_done SHALL register i_rx_data into o_alu_b and go to GET_OP.
REQ-023 GET_OP: an i_rx_done SHALL register i_rx_data[NB_OP-1:0] into o_alu_op, discard the upper bits, and go to EXEC.
REQ-024 EXEC: o_alu_valid SHALL be 1 for exactly this one cycle, i_alu_result SHALL be registered into o_tx_data at the end of the cycle, and the FSM SHALL go to SEND.
REQ-025 SEND: o_tx_start SHALL be 1 for exactly one cycle while o_tx_data is stable, then the FSM SHALL go to WAIT_TX.
REQ-026 WAIT_TX: an i_tx_done SHALL return the FSM to IDLE.
REQ-027 The latency from the i_rx_done of the opcode byte to o_tx_start SHALL be exactly 2 cycles (EXEC, then SEND).
REQ-028 An i_rx_done in EXEC, SEND or WAIT_TX SHALL drop the byte, pulse o_frame_err, and leave the state unchanged (overrun).
REQ-029 An i_tx_done outside WAIT_TX SHALL be ignored.
REQ-030 o_alu_a, o_alu_b, o_alu_op and o_tx_data SHALL hold their values until they are overwritten by the next frame.
REQ-031 o_alu_valid, o_tx_start and o_frame_err SHALL never be high for two consecutive cycles from a single event.

Reset
REQ-032 Assertion of i_rst_n=0 SHALL immediately force state IDLE and set all outputs and the timeout counter to 0, including when reset occurs mid-frame or mid-transmit.
REQ-033 After reset deassertion, the first accepted frame SHALL start with SYNC_BYTE; partial-frame bytes received before reset SHALL be forgotten.

Configuration
REQ-034 When UART_ALU_SEQ_TIMEOUT_EN is defined, a counter SHALL clear on entry to GET_A, GET_B or GET_OP and on every i_rx_done in those states, and SHALL increment each cycle otherwise while in those states.
REQ-035 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and pulse o_frame_err; this SHALL take effect on the same cycle and override any simultaneous i_rx_done.
REQ-036 When UART_ALU_SEQ_TIMEOUT_EN is not defined, no counter SHALL exist and the GET_* states SHALL wait indefinitely.

Verification
REQ-037 The bench SHALL send bytes A5,03,05,20 with an adder ALU model and check a=03, b=05, op=20, one-cycle o_alu_valid, o_tx_start 2 cycles after the last i_rx_done with o_tx_data=08, and IDLE after i_tx_done.
REQ-038 The bench SHALL send byte 11 in IDLE and check one o_frame_err pulse, o_busy=0, and outputs unchanged; it SHALL then send a valid frame and check it completes normally.
REQ-039 The bench SHALL send A5,7F,FF,3F and check that o_alu_op=3F; it SHALL also send FF as the opcode byte and check that o_alu_op=3F with the upper bits discarded.
REQ-040 The bench SHALL send a byte during WAIT_TX and check one o_frame_err pulse, that o_tx_data is unchanged, and a return to IDLE on i_tx_done.
REQ-041 The bench SHALL assert i_rst_n after A5,03, then send 04,A5,01,02,00 and check that 04 is rejected with o_frame_err and the frame executes with a=01, b=02.
REQ-042 With UART_ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, the bench SHALL send A5 and then idle, and check o_frame_err and IDLE exactly 20 cycles after entry to GET_A.
